ahb_decoder_pipe: RTL

AHB_DECODER_PIPE -- requirements
Module: ahb_decoder_pipe

---
 rtl/ahb_decoder_pipe_pkg.sv | 57 +++++
 rtl/ahb_decoder_pipe_addr_cmp.sv | 16 +
 rtl/ahb_decoder_pipe.sv | 119 +++++++++++
 3 files changed

// File: rtl/ahb_decoder_pipe_pkg.sv
// Purpose: shared AHB types, decoder state encoding and the per-slave address map.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: htrans_type, hresp_type, dec_state_t, AHB_SLV_LOW_ADDR/AHB_SLV_HIGH_ADDR,
//           slv_swap_idx() which gives the range index a slave uses while remap is active.
package AHB_package;

    localparam int AHB_SLV_MAX = 16;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_type;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_type;

    typedef enum logic [1:0] {
        DEC_IDLE   = 2'b00,
        DEC_SLVSEL = 2'b01,
        DEC_ERROR  = 2'b10
    } dec_state_t;

    // Held at 64 bits so any AHB_ADDR_WIDTH up to 64 can slice its low bits.
    // Slaves 0..3 tile the first 4KB in 1KB windows; 0x1000..0xFFFF is
    // deliberately unmapped so it lands on the default slave.
    localparam logic [63:0] AHB_SLV_LOW_ADDR [AHB_SLV_MAX] = '{
        64'h0000_0000, 64'h0000_0400, 64'h0000_0800, 64'h0000_0C00,
        64'h0001_0000, 64'h0001_1000, 64'h0001_2000, 64'h0001_3000,
        64'h0001_4000, 64'h0001_5000, 64'h0001_6000, 64'h0001_7000,
        64'h0001_8000, 64'h0001_9000, 64'h0001_A000, 64'h0001_B000
    };

    localparam logic [63:0] AHB_SLV_HIGH_ADDR [AHB_SLV_MAX] = '{
        64'h0000_03FF, 64'h0000_07FF, 64'h0000_0BFF, 64'h0000_0FFF,
        64'h0001_0FFF, 64'h0001_1FFF, 64'h0001_2FFF, 64'h0001_3FFF,
        64'h0001_4FFF, 64'h0001_5FFF, 64'h0001_6FFF, 64'h0001_7FFF,
        64'h0001_8FFF, 64'h0001_9FFF, 64'h0001_AFFF, 64'h0001_BFFF
    };

    // Boot remap swaps the windows of slave 0 and slave 1; others keep their own.
    function automatic int slv_swap_idx(input int idx);
        if (idx == 0)
            return 1;
        else if (idx == 1)
            return 0;
        else
            return idx;
    endfunction

endpackage

// File: rtl/ahb_decoder_pipe_addr_cmp.sv
// Purpose: single inclusive address range compare for one slave window.
// Latency: combinational.
// Backpressure: none.
// Ports: addr, low_addr, high_addr in; hit out (low_addr <= addr <= high_addr).
module ahb_addr_cmp #(
    parameter int AHB_ADDR_WIDTH = 32
) (
    input  logic [AHB_ADDR_WIDTH-1:0] addr,
    input  logic [AHB_ADDR_WIDTH-1:0] low_addr,
    input  logic [AHB_ADDR_WIDTH-1:0] high_addr,
    output logic                      hit
);

    assign hit = (addr >= low_addr) && (addr <= high_addr);

endmodule

// File: rtl/ahb_decoder_pipe.sv
// Purpose: registered AHB address decoder with boot remap and per-slave split tracking.
// Latency: hreq/default_slv_sel update one cycle after an accepted address phase.
// Backpressure: hready=0 freezes the selection; only split_pend may change during a stall.
// Ports: hclk/hreset_n; haddr, htrans, hready, hresp, hremap, hsplit in;
//        hreq (one-hot), default_slv_sel, split_pend out.
module ahb_decoder_pipe
    import AHB_package::*;
#(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int SLV_NUM        = 4,
    parameter int REMAP_EN       = 1
) (
    input  logic                      hclk,
    input  logic                      hreset_n,
    input  logic [AHB_ADDR_WIDTH-1:0] haddr,
    input  htrans_type                htrans,
    input  logic                      hready,
    input  hresp_type                 hresp,
    input  logic                      hremap,
    input  logic [SLV_NUM-1:0]        hsplit,
    output logic [SLV_NUM-1:0]        hreq,
    output logic                      default_slv_sel,
    output logic [SLV_NUM-1:0]        split_pend
);

    logic               remap_act;
    logic [SLV_NUM-1:0] hit;
    logic [SLV_NUM-1:0] dec_onehot;
    logic               dec_ok;
    logic [SLV_NUM-1:0] split_set;
    dec_state_t         state;

    assign remap_act = (REMAP_EN != 0) && hremap;

    for (genvar i = 0; i < SLV_NUM; i++) begin : g_slv
        localparam int SWP = slv_swap_idx(i);

        logic [AHB_ADDR_WIDTH-1:0] low_addr;
        logic [AHB_ADDR_WIDTH-1:0] high_addr;

        assign low_addr  = remap_act ? AHB_SLV_LOW_ADDR[SWP][AHB_ADDR_WIDTH-1:0]
                                     : AHB_SLV_LOW_ADDR[i][AHB_ADDR_WIDTH-1:0];
        assign high_addr = remap_act ? AHB_SLV_HIGH_ADDR[SWP][AHB_ADDR_WIDTH-1:0]
                                     : AHB_SLV_HIGH_ADDR[i][AHB_ADDR_WIDTH-1:0];

        ahb_addr_cmp #(
            .AHB_ADDR_WIDTH (AHB_ADDR_WIDTH)
        ) u_addr_cmp (
            .addr      (haddr),
            .low_addr  (low_addr),
            .high_addr (high_addr),
            .hit       (hit[i])
        );
    end

    // Scan from the top so the last (lowest) hit overwrites: keeps hreq one-hot
    // even if windows overlap.
    always_comb begin
        dec_onehot = '0;
        for (int i = SLV_NUM - 1; i >= 0; i--) begin
            if (hit[i]) begin
                dec_onehot    = '0;
                dec_onehot[i] = 1'b1;
            end
        end
    end

    // No hit gives an all-zero one-hot, so a single AND covers both
    // "unmapped" and "target is split-pending".
    assign dec_ok = |(dec_onehot & ~split_pend);

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state           <= DEC_IDLE;
            hreq            <= '0;
            default_slv_sel <= 1'b0;
        end else if (hready) begin
            case (htrans)
                HTRANS_IDLE: begin
                    if (state != DEC_IDLE) begin
                        state           <= DEC_IDLE;
                        hreq            <= '0;
                        default_slv_sel <= 1'b0;
                    end
                end
                HTRANS_BUSY: begin
                    // Burst paused: keep the current target selected.
                end
                HTRANS_NONSEQ, HTRANS_SEQ: begin
                    // Every beat re-decodes, so a burst crossing a window edge
                    // simply moves to the next slave.
                    if (dec_ok) begin
                        state           <= DEC_SLVSEL;
                        hreq            <= dec_onehot;
                        default_slv_sel <= 1'b0;
                    end else begin
                        state           <= DEC_ERROR;
                        hreq            <= '0;
                        default_slv_sel <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // First SPLIT response cycle (hready low) marks the selected slave; the
    // unsplit pulse is applied last so it wins a same-cycle collision.
    assign split_set = ((hresp == HRESP_SPLIT) && !hready) ? hreq : '0;

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n)
            split_pend <= '0;
        else
            split_pend <= (split_pend | split_set) & ~hsplit;
    end

endmodule
